// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - register map, CTRL layout and byte-merge helper for hex_disp_regs
package hex_disp_pkg;

    localparam logic [3:0] VALUE_OFF    = 4'h0;
    localparam logic [3:0] CTRL_OFF     = 4'h4;
    localparam logic [3:0] PRESCALE_OFF = 4'h8;
    localparam logic [3:0] STATUS_OFF   = 4'hC;

    localparam int CTRL_COUNT_EN_BIT   = 0;
    localparam int CTRL_COUNT_DOWN_BIT = 1;
    localparam int CTRL_BLANK_BIT      = 2;
    localparam int CTRL_BLINK_BIT      = 3;

    localparam int STATUS_WRAP_BIT = 0;

    typedef struct packed {
        logic blink;
        logic blank;
        logic count_down;
        logic count_en;
    } ctrl_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_disp_tick_gen.sv
// rtl/hex_disp_tick_gen.sv - free-running prescaler, one-cycle tick when the count reaches limit
module hex_disp_tick_gen
    import hex_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [31:0] limit,
    output logic        tick
);

    logic [31:0] pcnt;

    assign tick = en && (pcnt == limit);

    always_ff @(posedge clk) begin
        if (rst || clear || !en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end

endmodule

// File: rtl/hex_disp_regs.sv
// rtl/hex_disp_regs.sv - display value register block with hardware counter; blink via HEX_DISP_BLINK_EN
module hex_disp_regs
    import hex_disp_pkg::*;
#(
    parameter int          COUNT_W        = 16,
    parameter logic [31:0] RESET_VALUE    = 32'h0,
    parameter logic [31:0] RESET_PRESCALE = 32'd49_999_999,
    parameter int          BLINK_DIV      = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic [31:0] disp_data_o,
    output logic        disp_blank_o
);

    localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF >> (32 - COUNT_W);
`ifdef HEX_DISP_BLINK_EN
    localparam logic [3:0] CTRL_MASK = 4'b1111;
`else
    localparam logic [3:0] CTRL_MASK = 4'b0111;
    localparam int UNUSED_BLINK_DIV = BLINK_DIV;
`endif

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] value_q, value_d;
    logic [31:0] prescale_q, prescale_d;
    logic        wrap_q, wrap_d;
    logic        blank_q, blank_d;
    logic        rvalid_q;
    logic [31:0] rdata_q, rd_mux;

    logic [3:0] reg_off;
    logic       wr, wr_value, wr_ctrl, wr_prescale, wr_status;
    logic       unused_addr;

    assign reg_off     = {device_addr_i[3:2], 2'b00};
    assign unused_addr = ^{device_addr_i[31:4], device_addr_i[1:0]};
    assign wr          = device_req_i && device_we_i;
    assign wr_value    = wr && (reg_off == VALUE_OFF);
    assign wr_ctrl     = wr && (reg_off == CTRL_OFF);
    assign wr_prescale = wr && (reg_off == PRESCALE_OFF);
    assign wr_status   = wr && (reg_off == STATUS_OFF);

    logic count_tick;

    hex_disp_tick_gen u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q.count_en),
        .clear (wr_ctrl || wr_prescale),
        .limit (prescale_q),
        .tick  (count_tick)
    );

    // Only the low COUNT_W bits take part in counting; the rest of VALUE is untouched.
    logic [31:0] cnt_low, cnt_next_low;
    logic        cnt_wraps;

    always_comb begin
        cnt_low = value_q & CNT_MASK;
        if (ctrl_q.count_down) begin
            cnt_next_low = (cnt_low - 32'd1) & CNT_MASK;
            cnt_wraps    = (cnt_low == 32'd0);
        end else begin
            cnt_next_low = (cnt_low + 32'd1) & CNT_MASK;
            cnt_wraps    = (cnt_low == CNT_MASK);
        end
    end

    always_comb begin
        value_d    = value_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        wrap_d     = wrap_q;
        if (wr_value) begin
            value_d = be_merge(value_q, device_wdata_i, device_be_i);
        end else if (count_tick) begin
            value_d = (value_q & ~CNT_MASK) | cnt_next_low;
        end
        if (wr_ctrl && device_be_i[0]) begin
            ctrl_d = ctrl_t'(device_wdata_i[3:0] & CTRL_MASK);
        end
        if (wr_prescale) begin
            prescale_d = be_merge(prescale_q, device_wdata_i, device_be_i);
        end
        if (wr_status && device_be_i[0] && device_wdata_i[STATUS_WRAP_BIT]) begin
            wrap_d = 1'b0;
        end
        // A wrap that lands in the same cycle as a clear must not be lost.
        if (count_tick && !wr_value && cnt_wraps) begin
            wrap_d = 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_off)
            VALUE_OFF:    rd_mux = value_q;
            CTRL_OFF:     rd_mux = {28'd0, ctrl_q};
            PRESCALE_OFF: rd_mux = prescale_q;
            STATUS_OFF:   rd_mux[STATUS_WRAP_BIT] = wrap_q;
            default:      rd_mux = '0;
        endcase
    end

`ifdef HEX_DISP_BLINK_EN
    logic blink_tick;
    logic phase_q, phase_d;

    hex_disp_tick_gen u_blink (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q.blink),
        .clear (1'b0),
        .limit (32'(BLINK_DIV - 1)),
        .tick  (blink_tick)
    );

    always_comb begin
        phase_d = 1'b0;
        if (ctrl_q.blink) begin
            phase_d = blink_tick ? !phase_q : phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign blank_d = ctrl_d.blank | (ctrl_d.blink & phase_d);
`else
    assign blank_d = ctrl_d.blank;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q    <= RESET_VALUE;
            ctrl_q     <= '0;
            prescale_q <= RESET_PRESCALE;
            wrap_q     <= 1'b0;
            blank_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            value_q    <= value_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            wrap_q     <= wrap_d;
            blank_q    <= blank_d;
            rvalid_q   <= device_req_i;
            rdata_q    <= (device_req_i && !device_we_i) ? rd_mux : 32'd0;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign disp_data_o     = value_q;
    assign disp_blank_o    = blank_q;

endmodule

// File: tb/tb_hex_disp_regs.sv
// tb/tb_hex_disp_regs.sv - self-checking bench for hex_disp_regs with cycle model and directed vectors
module tb_hex_disp_regs;

    localparam int          COUNT_W   = 16;
    localparam logic [31:0] RV        = 32'h0;
    localparam logic [31:0] RP        = 32'd49_999_999;
    localparam int          BLINK_DIV = 4;
    localparam logic [31:0] MASK      = 32'((64'd1 << COUNT_W) - 64'd1);
`ifdef HEX_DISP_BLINK_EN
    localparam logic [3:0] CMASK = 4'b1111;
`else
    localparam logic [3:0] CMASK = 4'b0111;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] disp_data;
    logic        disp_blank;

    int tests = 0;
    int fails = 0;

    hex_disp_regs #(
        .COUNT_W        (COUNT_W),
        .RESET_VALUE    (RV),
        .RESET_PRESCALE (RP),
        .BLINK_DIV      (BLINK_DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .disp_data_o     (disp_data),
        .disp_blank_o    (disp_blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as plain variables, prescaler as "cycles left until the next tick".
    logic [31:0] m_value, m_pre, e_rdata;
    logic [3:0]  m_ctrl;
    logic        m_wrap, m_phase, e_rvalid, e_blank, model_ok = 1'b0;
    longint      m_left, m_bleft;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] bm;
        bm = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (n & bm) | (o & ~bm);
    endfunction

    always @(posedge clk) begin
        logic        tick, old_en, clr;
        logic [31:0] low;
        if (rst) begin
            m_value = RV; m_ctrl = '0; m_pre = RP; m_wrap = 1'b0;
            m_left = longint'(RP); m_phase = 1'b0; m_bleft = BLINK_DIV - 1;
            e_rvalid = 1'b0; e_rdata = '0;
        end else begin
            old_en = m_ctrl[0];
            tick   = old_en && (m_left == 0);
            clr    = req && we && (addr[3:2] == 2'd1 || addr[3:2] == 2'd2);
            e_rvalid = req;
            e_rdata  = '0;
            if (req && !we) begin
                case (addr[3:2])
                    2'd0: e_rdata = m_value;
                    2'd1: e_rdata = {28'd0, m_ctrl};
                    2'd2: e_rdata = m_pre;
                    default: e_rdata = {31'd0, m_wrap};
                endcase
            end
`ifdef HEX_DISP_BLINK_EN
            if (!m_ctrl[3]) begin
                m_phase = 1'b0; m_bleft = BLINK_DIV - 1;
            end else if (m_bleft == 0) begin
                m_phase = !m_phase; m_bleft = BLINK_DIV - 1;
            end else begin
                m_bleft--;
            end
`endif
            if (req && we && addr[3:2] == 2'd3 && be[0] && wdata[0]) m_wrap = 1'b0;
            if (req && we && addr[3:2] == 2'd0) begin
                m_value = merge(m_value, wdata, be);
            end else if (tick) begin
                low = m_value & MASK;
                if (m_ctrl[1]) begin
                    if (low == 0) begin m_wrap = 1'b1; low = MASK; end
                    else low = low - 1;
                end else begin
                    if (low == MASK) begin m_wrap = 1'b1; low = 0; end
                    else low = low + 1;
                end
                m_value = (m_value & ~MASK) | low;
            end
            if (req && we && addr[3:2] == 2'd1 && be[0]) m_ctrl = wdata[3:0] & CMASK;
            if (req && we && addr[3:2] == 2'd2) m_pre = merge(m_pre, wdata, be);
            if (!old_en || clr || tick) m_left = longint'(m_pre);
            else m_left--;
        end
        e_blank  = m_ctrl[2] | (m_ctrl[3] & m_phase);
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("rvalid", {31'd0, rvalid}, {31'd0, e_rvalid});
            check("rdata", rdata, e_rdata);
            check("disp_data", disp_data, m_value);
            check("disp_blank", {31'd0, disp_blank}, {31'd0, e_blank});
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus(1'b0, a, 4'h0, 32'h0);
        @(negedge clk);
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
        step(2);
        rst = 1'b0;

        rd(32'h0, v); check("reset_value", v, 32'h0);
        rd(32'h4, v); check("reset_ctrl", v, 32'h0);
        rd(32'h8, v); check("reset_prescale", v, 32'd49_999_999);
        rd(32'hC, v); check("reset_status", v, 32'h0);

        bus(1'b1, 32'h0, 4'b0011, 32'h1234_ABCD);
        check("be_disp", disp_data, 32'h0000_ABCD);
        rd(32'h0, v); check("be_read", v, 32'h0000_ABCD);

        bus(1'b0, 32'h0, 4'h0, 32'h0);
        bus(1'b0, 32'h8, 4'h0, 32'h0);
        bus(1'b1, 32'h8, 4'hF, 32'd3);
        bus(1'b1, 32'h0, 4'hF, 32'h0000_FFFE);
        bus(1'b1, 32'h4, 4'h1, 32'h1);
        step(3);
        check("up_pre", disp_data, 32'h0000_FFFE);
        step(1);
        check("up_ffff", disp_data, 32'h0000_FFFF);
        step(4);
        check("up_wrap0", disp_data, 32'h0000_0000);
        rd(32'hC, v); check("wrap_set", v, 32'h1);
        bus(1'b1, 32'h4, 4'h1, 32'h0);
        bus(1'b1, 32'hC, 4'h1, 32'h0);
        rd(32'hC, v); check("wrap_w0", v, 32'h1);
        bus(1'b1, 32'hC, 4'h1, 32'h1);
        rd(32'hC, v); check("wrap_clr", v, 32'h0);

        bus(1'b1, 32'h8, 4'hF, 32'd0);
        bus(1'b1, 32'h0, 4'hF, 32'd5);
        bus(1'b1, 32'h4, 4'h1, 32'h3);
        check("dn_5", disp_data, 32'd5);
        step(1); check("dn_4", disp_data, 32'd4);
        step(1); check("dn_3", disp_data, 32'd3);
        step(1); check("dn_2", disp_data, 32'd2);
        bus(1'b1, 32'h0, 4'hF, 32'd100);
        check("wr_wins", disp_data, 32'd100);
        step(1); check("after_wr", disp_data, 32'd99);
        step(120);
        rd(32'hC, v); check("dn_wrap", v, 32'h1);

        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0;
        step(1);
        rst = 1'b0; req = 1'b0;
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_disp", disp_data, 32'h0);
        rd(32'h4, v); check("rst_ctrl", v, 32'h0);
        rd(32'h8, v); check("rst_prescale", v, 32'd49_999_999);
        rd(32'hC, v); check("rst_status", v, 32'h0);

        bus(1'b1, 32'h4, 4'h1, 32'h4);
        check("blank_on", {31'd0, disp_blank}, 32'd1);
        bus(1'b1, 32'h4, 4'h1, 32'h0);
        check("blank_off", {31'd0, disp_blank}, 32'd0);

`ifdef HEX_DISP_BLINK_EN
        bus(1'b1, 32'h4, 4'h1, 32'h8);
        for (int i = 0; i < 12; i++) begin
            check("blink", {31'd0, disp_blank}, {31'd0, ((i / 4) % 2) == 1});
            step(1);
        end
        bus(1'b1, 32'h4, 4'h1, 32'h0);
`else
        bus(1'b1, 32'h4, 4'h1, 32'h8);
        rd(32'h4, v); check("no_blink_bit", v, 32'h0);
        check("no_blink_blank", {31'd0, disp_blank}, 32'd0);
`endif
        step(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
